// File: rtl/mrnaiso_valve_sequencer_if.sv
// Host-side bus of the mRNA isolation valve sequencer.
// Optional loop_count port exists when MRNAISO_SEQ_LOOP_EN is defined.
interface mrnaiso_valve_sequencer_if #(
  parameter int CTRL_SIZE = 13,
  parameter int NUM_STEPS = 8,
  parameter int DWELL_W   = 16
);
  localparam int AW = $clog2(NUM_STEPS);

  logic                 step_we;
  logic [AW-1:0]        step_addr;
  logic [CTRL_SIZE-1:0] step_ctrl;
  logic                 step_pump_en;
  logic                 step_pump_rev;
  logic                 step_last;
  logic [DWELL_W-1:0]   step_dwell;
  logic                 start;
  logic                 abort;
`ifdef MRNAISO_SEQ_LOOP_EN
  logic [7:0]           loop_count;
`endif
  logic                 busy;
  logic                 done;
  logic                 aborted;
  logic [AW-1:0]        cur_step;

  modport master (
`ifdef MRNAISO_SEQ_LOOP_EN
    output loop_count,
`endif
    output step_we, step_addr, step_ctrl,
    output step_pump_en, step_pump_rev,
    output step_last, step_dwell,
    output start, abort,
    input  busy, done, aborted, cur_step
  );

  modport slave (
`ifdef MRNAISO_SEQ_LOOP_EN
    input  loop_count,
`endif
    input  step_we, step_addr, step_ctrl,
    input  step_pump_en, step_pump_rev,
    input  step_last, step_dwell,
    input  start, abort,
    output busy, done, aborted, cur_step
  );
endinterface

// File: rtl/mrnaiso_valve_sequencer.sv
// Program-table valve/pump sequencer for the mRNA isolation group.
// Define MRNAISO_SEQ_LOOP_EN to repeat the program loop_count+1 times.
module mrnaiso_valve_sequencer #(
  parameter int CTRL_SIZE = 13,
  parameter int PUMP_SIZE = 3,
  parameter int NUM_STEPS = 8,
  parameter int DWELL_W   = 16,
  parameter int PUMP_DIV  = 4,
  parameter logic [CTRL_SIZE-1:0] SAFE_CTRL = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mrnaiso_valve_sequencer_if.slave bus,
  output logic [CTRL_SIZE-1:0] ctrl,
  output logic [PUMP_SIZE-1:0] pump
);
  localparam int AW    = $clog2(NUM_STEPS);
  localparam int DIV_W = $clog2(PUMP_DIV + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH,
    S_ABORT
  } state_e;

  state_e state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [1:0]           ph_q, ph_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CTRL_SIZE-1:0] ctrl_q, ctrl_d;
  logic [PUMP_SIZE-1:0] pump_q, pump_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 abrt_q, abrt_d;
  logic [AW-1:0]        step_q, step_d;
  logic                 enter;
  logic                 run_d;
`ifdef MRNAISO_SEQ_LOOP_EN
  logic [7:0]           loops_q, loops_d;
`endif

  logic [CTRL_SIZE-1:0] tbl_ctrl  [NUM_STEPS];
  logic                 tbl_en    [NUM_STEPS];
  logic                 tbl_rev   [NUM_STEPS];
  logic                 tbl_last  [NUM_STEPS];
  logic [DWELL_W-1:0]   tbl_dwell [NUM_STEPS];

  // Table is frozen while a program runs.
  always_ff @(posedge clk) begin
    if (bus.step_we && !busy_q) begin
      tbl_ctrl[bus.step_addr]  <= bus.step_ctrl;
      tbl_en[bus.step_addr]    <= bus.step_pump_en;
      tbl_rev[bus.step_addr]   <= bus.step_pump_rev;
      tbl_last[bus.step_addr]  <= bus.step_last;
      tbl_dwell[bus.step_addr] <= bus.step_dwell;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    div_d   = div_q;
    enter   = 1'b0;
`ifdef MRNAISO_SEQ_LOOP_EN
    loops_d = loops_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          idx_d   = '0;
          enter   = 1'b1;
`ifdef MRNAISO_SEQ_LOOP_EN
          loops_d = bus.loop_count;
`endif
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_ABORT;
        end else if (cnt_q == '0) begin
          if (tbl_last[idx_q] ||
              idx_q == AW'(NUM_STEPS - 1)) begin
`ifdef MRNAISO_SEQ_LOOP_EN
            if (loops_q != 8'd0) begin
              loops_d = loops_q - 8'd1;
              idx_d   = '0;
              enter   = 1'b1;
            end else begin
              state_d = S_FINISH;
            end
`else
            state_d = S_FINISH;
`endif
          end else begin
            idx_d = idx_q + AW'(1);
            enter = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
          if (div_q == DIV_W'(PUMP_DIV - 1)) begin
            div_d = '0;
            ph_d  = (ph_q == 2'd2) ? 2'd0 : ph_q + 2'd1;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      S_ABORT:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Counter holds remaining cycles after this one; dwell 0 acts as 1.
    if (enter) begin
      cnt_d = (tbl_dwell[idx_d] == '0) ? '0 :
              tbl_dwell[idx_d] - DWELL_W'(1);
      ph_d  = 2'd0;
      div_d = '0;
    end
  end

  always_comb begin
    run_d  = (state_d == S_RUN);
    ctrl_d = run_d ? tbl_ctrl[idx_d] : SAFE_CTRL;
    pump_d = '1;
    if (run_d && tbl_en[idx_d]) begin
      unique case (1'b1)
        (ph_d == 2'd0):
          pump_d = tbl_rev[idx_d] ? 3'b011 : 3'b110;
        (ph_d == 2'd1):
          pump_d = 3'b101;
        default:
          pump_d = tbl_rev[idx_d] ? 3'b110 : 3'b011;
      endcase
    end
    busy_d = run_d;
    done_d = (state_d == S_FINISH);
    abrt_d = (state_d == S_ABORT);
    step_d = run_d ? idx_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= 2'd0;
      div_q   <= '0;
      ctrl_q  <= SAFE_CTRL;
      pump_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abrt_q  <= 1'b0;
      step_q  <= '0;
`ifdef MRNAISO_SEQ_LOOP_EN
      loops_q <= 8'd0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      div_q   <= div_d;
      ctrl_q  <= ctrl_d;
      pump_q  <= pump_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abrt_q  <= abrt_d;
      step_q  <= step_d;
`ifdef MRNAISO_SEQ_LOOP_EN
      loops_q <= loops_d;
`endif
    end
  end

  assign ctrl         = ctrl_q;
  assign pump         = pump_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.aborted  = abrt_q;
  assign bus.cur_step = step_q;
endmodule

// File: tb/tb_mrnaiso_valve_sequencer.sv
// Randomized self-checking bench for mrnaiso_valve_sequencer.
// Expected traces are expanded from the step table by a simple model.
module tb_mrnaiso_valve_sequencer;
  localparam int PD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] ctrl;
  logic [2:0]  pump;

  always #5 clk = ~clk;

  mrnaiso_valve_sequencer_if bus ();

  mrnaiso_valve_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .ctrl  (ctrl),
    .pump  (pump)
  );

  logic [12:0] m_ctrl  [8];
  bit          m_en    [8];
  bit          m_rev   [8];
  bit          m_last  [8];
  int          m_dwell [8];

  logic [12:0] qc [$];
  logic [2:0]  qp [$];
  int          qs [$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(string tag);
    chk({tag, ".ctrl"}, int'(ctrl), 'h1FFF);
    chk({tag, ".pump"}, int'(pump), 7);
    chk({tag, ".busy"}, int'(bus.busy), 0);
    chk({tag, ".done"}, int'(bus.done), 0);
    chk({tag, ".abrt"}, int'(bus.aborted), 0);
    chk({tag, ".step"}, int'(bus.cur_step), 0);
  endtask

  function automatic logic [2:0] pat(bit en, bit rev, int k);
    int p;
    p = (k / PD) % 3;
    if (!en) return 3'b111;
    if (p == 1) return 3'b101;
    if (p == 0) return rev ? 3'b011 : 3'b110;
    return rev ? 3'b110 : 3'b011;
  endfunction

  task automatic wr(int a, logic [12:0] c, bit en,
                    bit rev, bit last, int d);
    bus.step_addr     = 3'(a);
    bus.step_ctrl     = c;
    bus.step_pump_en  = en;
    bus.step_pump_rev = rev;
    bus.step_last     = last;
    bus.step_dwell    = 16'(d);
    bus.step_we       = 1'b1;
    tick();
    bus.step_we = 1'b0;
    m_ctrl[a]  = c;
    m_en[a]    = en;
    m_rev[a]   = rev;
    m_last[a]  = last;
    m_dwell[a] = d;
  endtask

  task automatic build(int passes);
    int d;
    qc.delete();
    qp.delete();
    qs.delete();
    for (int p = 0; p < passes; p++) begin
      for (int s = 0; s < 8; s++) begin
        d = (m_dwell[s] == 0) ? 1 : m_dwell[s];
        for (int k = 0; k < d; k++) begin
          qc.push_back(m_ctrl[s]);
          qp.push_back(pat(m_en[s], m_rev[s], k));
          qs.push_back(s);
        end
        if (m_last[s]) break;
      end
    end
  endtask

  // abort_at/disturb are RUN-cycle indices, -1 disables.
  task automatic run_prog(string tag, int abort_at,
                          int disturb, bit ab_start,
                          int loops);
    int passes;
    passes = 1;
`ifdef MRNAISO_SEQ_LOOP_EN
    passes = loops + 1;
    bus.loop_count = 8'(loops);
`endif
    build(passes);
    chk_idle({tag, ".pre"});
    bus.start = 1'b1;
    bus.abort = ab_start;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    for (int i = 0; i < qc.size(); i++) begin
      chk({tag, ".ctrl"}, int'(ctrl), int'(qc[i]));
      chk({tag, ".pump"}, int'(pump), int'(qp[i]));
      chk({tag, ".step"}, int'(bus.cur_step), qs[i]);
      chk({tag, ".busy"}, int'(bus.busy), 1);
      chk({tag, ".done"}, int'(bus.done), 0);
      chk({tag, ".abrt"}, int'(bus.aborted), 0);
      if (i == disturb) begin
        bus.start         = 1'b1;
        bus.step_addr     = 3'd1;
        bus.step_ctrl     = 13'($urandom);
        bus.step_pump_en  = 1'($urandom);
        bus.step_pump_rev = 1'($urandom);
        bus.step_last     = 1'($urandom);
        bus.step_dwell    = 16'($urandom_range(0, 9));
        bus.step_we       = 1'b1;
      end
      if (i == abort_at) bus.abort = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.step_we = 1'b0;
      bus.abort   = 1'b0;
      if (i == abort_at) begin
        chk({tag, ".ab_pulse"}, int'(bus.aborted), 1);
        chk({tag, ".ab_ctrl"}, int'(ctrl), 'h1FFF);
        chk({tag, ".ab_pump"}, int'(pump), 7);
        chk({tag, ".ab_busy"}, int'(bus.busy), 0);
        chk({tag, ".ab_done"}, int'(bus.done), 0);
        tick();
        chk_idle({tag, ".ab_post"});
        return;
      end
    end
    chk({tag, ".fin_done"}, int'(bus.done), 1);
    chk({tag, ".fin_busy"}, int'(bus.busy), 0);
    chk({tag, ".fin_ctrl"}, int'(ctrl), 'h1FFF);
    chk({tag, ".fin_pump"}, int'(pump), 7);
    chk({tag, ".fin_abrt"}, int'(bus.aborted), 0);
    chk({tag, ".fin_step"}, int'(bus.cur_step), 0);
    tick();
    chk_idle({tag, ".post"});
  endtask

  initial begin
    int ab;
    int di;
    int lp;
    rst_n = 1'b0;
    bus.step_we = 1'b0;
    bus.step_addr = '0;
    bus.step_ctrl = '0;
    bus.step_pump_en = 1'b0;
    bus.step_pump_rev = 1'b0;
    bus.step_last = 1'b0;
    bus.step_dwell = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef MRNAISO_SEQ_LOOP_EN
    bus.loop_count = 8'd0;
`endif
    tick();
    tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 8; s++)
      wr(s, 13'h1000, 1'b0, 1'b0, 1'b0, 1);
    wr(0, 13'h0001, 1'b0, 1'b0, 1'b0, 3);
    wr(1, 13'h0002, 1'b0, 1'b0, 1'b0, 5);
    wr(2, 13'h0004, 1'b0, 1'b0, 1'b1, 2);
    run_prog("basic", -1, -1, 1'b0, 0);

    wr(0, 13'h0AAA, 1'b1, 1'b0, 1'b1, 24);
    run_prog("pump_fwd", -1, -1, 1'b0, 0);
    wr(0, 13'h0AAA, 1'b1, 1'b1, 1'b1, 24);
    run_prog("pump_rev", -1, -1, 1'b0, 0);

    wr(0, 13'h0555, 1'b1, 1'b0, 1'b1, 100);
    run_prog("abort", 1, -1, 1'b0, 0);

    for (int s = 0; s < 8; s++)
      wr(s, 13'(s + 16), 1'b0, 1'b0, 1'b0, 0);
    run_prog("dwell0", -1, -1, 1'b0, 0);

    wr(0, 13'h0001, 1'b0, 1'b0, 1'b0, 3);
    wr(1, 13'h0002, 1'b0, 1'b0, 1'b0, 5);
    wr(2, 13'h0004, 1'b0, 1'b0, 1'b1, 2);
    run_prog("busy_wr", -1, 2, 1'b0, 0);
    run_prog("rerun", -1, -1, 1'b0, 0);

    run_prog("start_abort", -1, -1, 1'b1, 0);
    run_prog("abort_expiry", 2, -1, 1'b0, 0);

    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("idle_abort");

`ifdef MRNAISO_SEQ_LOOP_EN
    wr(0, 13'h0011, 1'b0, 1'b0, 1'b0, 2);
    wr(1, 13'h0022, 1'b0, 1'b0, 1'b1, 2);
    run_prog("loop3", -1, -1, 1'b0, 2);
`endif

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_idle("mid_reset");
    #2;
    rst_n = 1'b1;
    tick();
    chk_idle("after_reset");

    for (int it = 0; it < 40; it++) begin
      for (int s = 0; s < 8; s++)
        wr(s, 13'($urandom), 1'($urandom),
           1'($urandom), ($urandom_range(0, 3) == 0),
           $urandom_range(0, 6));
      lp = 0;
`ifdef MRNAISO_SEQ_LOOP_EN
      lp = $urandom_range(0, 2);
`endif
      build(lp + 1);
      ab = -1;
      di = -1;
      if ($urandom_range(0, 2) == 0)
        ab = $urandom_range(0, qc.size() - 1);
      if ($urandom_range(0, 1) == 0)
        di = $urandom_range(0, qc.size() - 1);
      run_prog("rand", ab, di, 1'($urandom), lp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
